// File: rtl/sap1_pkg.sv
// SAP-1 shared definitions: control-word bit positions, FSM state type, default widths.
package sap1_pkg;

  localparam int SAP1_DATA_W = 8;
  localparam int SAP1_ADDR_W = 4;
  localparam int CTRL_W      = 12;

  // Control-word bit indices, all active-high.
  localparam int CP = 11;
  localparam int EP = 10;
  localparam int LM = 9;
  localparam int CE = 8;
  localparam int LI = 7;
  localparam int EI = 6;
  localparam int LA = 5;
  localparam int EA = 4;
  localparam int SU = 3;
  localparam int EU = 2;
  localparam int LB = 1;
  localparam int LO = 0;

  typedef enum logic {
    PROG = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sap1_ram16x8.sv
// 2**ADDR_W x DATA_W RAM: write lands at the clock edge, read is combinational (zero latency); never stalls.
// With SAP1_MEM_PARITY_EN each word carries an even-parity bit and par_err_o flags a mismatch on the read port.
module sap1_ram16x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
`ifdef SAP1_MEM_PARITY_EN
  output logic              par_err_o,
`endif
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Contents are deliberately not reset so a loaded program survives rstn_i.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

`ifdef SAP1_MEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) par_mem[waddr_i] <= ^wdata_i;
  end

  // Stored bit makes data+parity even; any odd total is an error.
  assign par_err_o = par_mem[raddr_i] ^ (^mem[raddr_i]);
`endif

endmodule

// File: rtl/sap1_mem_unit.sv
// SAP-1 fetch/memory stage (PC, MAR, RAM, PROG/RUN FSM); bus_o is combinational, all else registered; program port never back-pressures in PROG.
// Optional per-word parity with sticky parity_err_o when SAP1_MEM_PARITY_EN is defined.
module sap1_mem_unit
  import sap1_pkg::*;
#(
  parameter int DATA_W = SAP1_DATA_W,
  parameter int ADDR_W = SAP1_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [CTRL_W-1:0] ctrl_word_i,
  input  logic [DATA_W-1:0] bus_i,
  output logic [DATA_W-1:0] bus_o,
  output logic              bus_oe_o,
  input  logic              prog_mode_i,
  input  logic              prog_valid_i,
  output logic              prog_ready_o,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [DATA_W-1:0] prog_data_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] mar_o,
  output logic              run_o,
`ifdef SAP1_MEM_PARITY_EN
  output logic              parity_err_o,
`endif
  output logic              bus_conflict_o
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] ram_rdata;
  logic              run_st;
  logic              cp_en, ep_en, lm_en, ce_en;
  logic              ram_we;

  assign run_st = (state_q == RUN);

  // Control bits only count in RUN; in PROG the controller word is ignored.
  assign cp_en = run_st & ctrl_word_i[CP];
  assign ep_en = run_st & ctrl_word_i[EP];
  assign lm_en = run_st & ctrl_word_i[LM];
  assign ce_en = run_st & ctrl_word_i[CE];

  assign ram_we = ~run_st & prog_valid_i;

  logic unused_bits;
  assign unused_bits = ^{ctrl_word_i[LI:LO], bus_i[DATA_W-1:ADDR_W]};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q        <= PROG;
      pc_q           <= '0;
      mar_q          <= '0;
      run_o          <= 1'b0;
      prog_ready_o   <= 1'b1;
      bus_conflict_o <= 1'b0;
    end else if (!run_st) begin
      if (!prog_mode_i) begin
        state_q      <= RUN;
        pc_q         <= '0;
        mar_q        <= '0;
        run_o        <= 1'b1;
        prog_ready_o <= 1'b0;
      end
    end else begin
      // Control bits still take effect on the edge that returns to PROG.
      if (cp_en)          pc_q           <= pc_q + 1'b1;
      if (lm_en)          mar_q          <= bus_i[ADDR_W-1:0];
      if (ep_en && ce_en) bus_conflict_o <= 1'b1;
      if (prog_mode_i) begin
        state_q      <= PROG;
        run_o        <= 1'b0;
        prog_ready_o <= 1'b1;
      end
    end
  end

  assign pc_o  = pc_q;
  assign mar_o = mar_q;

  // Ep wins over CE when both drive the bus.
  always_comb begin
    bus_o    = '0;
    bus_oe_o = 1'b0;
    if (ep_en) begin
      bus_o    = DATA_W'(pc_q);
      bus_oe_o = 1'b1;
    end else if (ce_en) begin
      bus_o    = ram_rdata;
      bus_oe_o = 1'b1;
    end
  end

`ifdef SAP1_MEM_PARITY_EN
  logic ram_par_err;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                  parity_err_o <= 1'b0;
    else if (ce_en && ram_par_err) parity_err_o <= 1'b1;
  end
`endif

  sap1_ram16x8 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (clk_i),
    .we_i      (ram_we),
    .waddr_i   (prog_addr_i),
    .wdata_i   (prog_data_i),
    .raddr_i   (mar_q),
`ifdef SAP1_MEM_PARITY_EN
    .par_err_o (ram_par_err),
`endif
    .rdata_o   (ram_rdata)
  );

endmodule

// File: tb/tb_sap1_mem_unit.sv
// Directed-vector bench for sap1_mem_unit: program load, fetch, PC wrap, bus priority, sticky conflict, async reset.
module tb_sap1_mem_unit;
  import sap1_pkg::*;

  localparam logic [11:0] C_NONE = 12'h000;
  localparam logic [11:0] C_CP   = 12'h800;
  localparam logic [11:0] C_EP   = 12'h400;
  localparam logic [11:0] C_LM   = 12'h200;
  localparam logic [11:0] C_CE   = 12'h100;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [11:0] ctrl_word_i;
  logic [7:0]  bus_i;
  logic [7:0]  bus_o;
  logic        bus_oe_o;
  logic        prog_mode_i;
  logic        prog_valid_i;
  logic        prog_ready_o;
  logic [3:0]  prog_addr_i;
  logic [7:0]  prog_data_i;
  logic [3:0]  pc_o;
  logic [3:0]  mar_o;
  logic        run_o;
  logic        bus_conflict_o;
`ifdef SAP1_MEM_PARITY_EN
  logic        parity_err_o;
`endif

  logic        loop_en;
  logic [7:0]  bus_drv;
  int          vecs = 0;
  int          errs = 0;

  assign bus_i = loop_en ? bus_o : bus_drv;

  always #5 clk_i = ~clk_i;

  sap1_mem_unit dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .ctrl_word_i    (ctrl_word_i),
    .bus_i          (bus_i),
    .bus_o          (bus_o),
    .bus_oe_o       (bus_oe_o),
    .prog_mode_i    (prog_mode_i),
    .prog_valid_i   (prog_valid_i),
    .prog_ready_o   (prog_ready_o),
    .prog_addr_i    (prog_addr_i),
    .prog_data_i    (prog_data_i),
    .pc_o           (pc_o),
    .mar_o          (mar_o),
    .run_o          (run_o),
`ifdef SAP1_MEM_PARITY_EN
    .parity_err_o   (parity_err_o),
`endif
    .bus_conflict_o (bus_conflict_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; ctrl_word_i = C_NONE; loop_en = 1'b0; bus_drv = 8'h00;
    prog_mode_i = 1'b1; prog_valid_i = 1'b0; prog_addr_i = 4'h0; prog_data_i = 8'h00;
    #12;
    vecs++; if (pc_o !== 4'h0) begin errs++; $display("FAIL reset_pc got %0h want 0", pc_o); end
    vecs++; if (mar_o !== 4'h0) begin errs++; $display("FAIL reset_mar got %0h want 0", mar_o); end
    vecs++; if (run_o !== 1'b0) begin errs++; $display("FAIL reset_run got %b want 0", run_o); end
    vecs++; if (bus_oe_o !== 1'b0 || bus_o !== 8'h00) begin errs++; $display("FAIL reset_bus got oe=%b bus=%h want 0/00", bus_oe_o, bus_o); end
    vecs++; if (prog_ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", prog_ready_o); end
    vecs++; if (bus_conflict_o !== 1'b0) begin errs++; $display("FAIL reset_conflict got %b want 0", bus_conflict_o); end
`ifdef SAP1_MEM_PARITY_EN
    vecs++; if (parity_err_o !== 1'b0) begin errs++; $display("FAIL reset_parity got %b want 0", parity_err_o); end
`endif
    @(negedge clk_i);
    rstn_i = 1'b1;
    step();
  endtask

  task automatic test_program();
    for (int i = 0; i < 16; i++) begin
      prog_valid_i = 1'b1;
      prog_addr_i  = 4'(i);
      prog_data_i  = 8'h10 + 8'(i);
      #1;
      vecs++; if (prog_ready_o !== 1'b1) begin errs++; $display("FAIL prog_ready[%0d] got %b want 1", i, prog_ready_o); end
      step();
    end
    prog_valid_i = 1'b0;
    prog_mode_i  = 1'b0;
    step();
    vecs++; if (run_o !== 1'b1) begin errs++; $display("FAIL enter_run got %b want 1", run_o); end
    vecs++; if (pc_o !== 4'h0 || mar_o !== 4'h0) begin errs++; $display("FAIL enter_run_regs got pc=%h mar=%h want 0/0", pc_o, mar_o); end
    vecs++; if (prog_ready_o !== 1'b0) begin errs++; $display("FAIL run_ready got %b want 0", prog_ready_o); end
  endtask

  task automatic test_fetch();
    ctrl_word_i = C_EP | C_LM; loop_en = 1'b1;
    #1;
    vecs++; if (bus_o !== 8'h00 || bus_oe_o !== 1'b1) begin errs++; $display("FAIL fetch_ep got bus=%h oe=%b want 00/1", bus_o, bus_oe_o); end
    step();
    ctrl_word_i = C_CE; loop_en = 1'b0;
    #1;
    vecs++; if (bus_o !== 8'h10 || bus_oe_o !== 1'b1) begin errs++; $display("FAIL fetch_ce got bus=%h oe=%b want 10/1", bus_o, bus_oe_o); end
    vecs++; if (mar_o !== 4'h0) begin errs++; $display("FAIL fetch_mar got %h want 0", mar_o); end
    ctrl_word_i = C_LM; bus_drv = 8'h06;
    step();
    ctrl_word_i = C_CE;
    #1;
    vecs++; if (bus_o !== 8'h16 || mar_o !== 4'h6) begin errs++; $display("FAIL fetch_ram6 got bus=%h mar=%h want 16/6", bus_o, mar_o); end
    step();
    ctrl_word_i = C_NONE;
    #1;
    vecs++; if (bus_oe_o !== 1'b0 || bus_o !== 8'h00) begin errs++; $display("FAIL idle_bus got oe=%b bus=%h want 0/00", bus_oe_o, bus_o); end
  endtask

  task automatic test_pc_wrap();
    logic [4:0] k5;
    ctrl_word_i = C_CP;
    for (int k = 1; k <= 17; k++) begin
      step();
      k5 = 5'(k);
      vecs++; if (pc_o !== k5[3:0]) begin errs++; $display("FAIL pc_wrap[%0d] got %h want %h", k, pc_o, k5[3:0]); end
    end
    ctrl_word_i = C_NONE;
  endtask

  task automatic test_ep_cp();
    ctrl_word_i = C_CP;
    repeat (4) step();
    ctrl_word_i = C_EP | C_CP;
    #1;
    vecs++; if (bus_o !== 8'h05 || bus_oe_o !== 1'b1) begin errs++; $display("FAIL ep_cp_bus got %h want 05", bus_o); end
    step();
    ctrl_word_i = C_NONE;
    vecs++; if (pc_o !== 4'h6) begin errs++; $display("FAIL ep_cp_pc got %h want 6", pc_o); end
  endtask

  task automatic test_conflict();
    ctrl_word_i = C_CP;
    repeat (13) step();
    vecs++; if (pc_o !== 4'h3) begin errs++; $display("FAIL conflict_pc got %h want 3", pc_o); end
    ctrl_word_i = C_LM; bus_drv = 8'h07;
    step();
    ctrl_word_i = C_EP | C_CE;
    #1;
    vecs++; if (bus_o !== 8'h03 || bus_conflict_o !== 1'b0) begin errs++; $display("FAIL conflict_bus got bus=%h flag=%b want 03/0", bus_o, bus_conflict_o); end
    step();
    ctrl_word_i = C_NONE;
    vecs++; if (bus_conflict_o !== 1'b1 || mar_o !== 4'h7) begin errs++; $display("FAIL conflict_set got flag=%b mar=%h want 1/7", bus_conflict_o, mar_o); end
    prog_addr_i = 4'h7; prog_data_i = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      prog_valid_i = i[0];
      step();
    end
    prog_valid_i = 1'b0;
    vecs++; if (bus_conflict_o !== 1'b1) begin errs++; $display("FAIL conflict_sticky got %b want 1", bus_conflict_o); end
    ctrl_word_i = C_CE;
    #1;
    vecs++; if (bus_o !== 8'h17) begin errs++; $display("FAIL run_nowrite got %h want 17", bus_o); end
    step();
    ctrl_word_i = C_NONE;
  endtask

  task automatic test_async_reset();
    ctrl_word_i = C_CP;
    repeat (6) step();
    ctrl_word_i = C_EP;
    #1;
    vecs++; if (pc_o !== 4'h9 || bus_oe_o !== 1'b1) begin errs++; $display("FAIL pre_reset got pc=%h oe=%b want 9/1", pc_o, bus_oe_o); end
    #1 rstn_i = 1'b0;
    #1;
    vecs++; if (pc_o !== 4'h0 || run_o !== 1'b0 || bus_oe_o !== 1'b0) begin errs++; $display("FAIL async_reset got pc=%h run=%b oe=%b want 0/0/0", pc_o, run_o, bus_oe_o); end
    vecs++; if (bus_conflict_o !== 1'b0 || prog_ready_o !== 1'b1) begin errs++; $display("FAIL async_reset_flags got flag=%b ready=%b want 0/1", bus_conflict_o, prog_ready_o); end
    rstn_i = 1'b1;
    ctrl_word_i = C_NONE;
    step();
    vecs++; if (run_o !== 1'b1) begin errs++; $display("FAIL rerun got %b want 1", run_o); end
    ctrl_word_i = C_LM; bus_drv = 8'hFC;
    step();
    vecs++; if (mar_o !== 4'hC) begin errs++; $display("FAIL mar_low_bits got %h want c", mar_o); end
    ctrl_word_i = C_CE;
    #1;
    vecs++; if (bus_o !== 8'h1C) begin errs++; $display("FAIL ram_kept got %h want 1c", bus_o); end
    step();
  endtask

  task automatic test_back_to_prog();
    ctrl_word_i = C_CP; prog_mode_i = 1'b1;
    step();
    vecs++; if (run_o !== 1'b0 || pc_o !== 4'h1 || prog_ready_o !== 1'b1) begin errs++; $display("FAIL to_prog got run=%b pc=%h ready=%b want 0/1/1", run_o, pc_o, prog_ready_o); end
    ctrl_word_i = C_CE | C_EP;
    #1;
    vecs++; if (bus_oe_o !== 1'b0 || bus_o !== 8'h00) begin errs++; $display("FAIL prog_ignores_ctrl got oe=%b bus=%h want 0/00", bus_oe_o, bus_o); end
    step();
    vecs++; if (bus_conflict_o !== 1'b0 || pc_o !== 4'h1) begin errs++; $display("FAIL prog_hold got flag=%b pc=%h want 0/1", bus_conflict_o, pc_o); end
`ifdef SAP1_MEM_PARITY_EN
    vecs++; if (parity_err_o !== 1'b0) begin errs++; $display("FAIL parity_clean got %b want 0", parity_err_o); end
`endif
    ctrl_word_i = C_NONE;
  endtask

  initial begin
    test_reset();
    test_program();
    test_fetch();
    test_pc_wrap();
    test_ep_cp();
    test_conflict();
    test_async_reset();
    test_back_to_prog();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sap1_mem_unit.md
Name: sap1_mem_unit

Overview:
- SAP-1 fetch/memory stage: the 4-bit program counter (PC), the 4-bit memory address register (MAR) and a 16x8 RAM.
- Sits directly downstream of the SAP-1 controller and consumes its 12-bit control word; drives the shared W-bus when enabled.
- Includes a program-load port with a valid/ready handshake, used to fill RAM before a run.

Parameters:
- DATA_W, 8, bus and RAM word width.
- ADDR_W, 4, PC/MAR width; RAM depth is 2**ADDR_W.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- ctrl_word_i  in  12  control word from the controller; bit order defined in sap1_pkg
- bus_i  in  DATA_W  W-bus value; MAR loads from bus_i[ADDR_W-1:0]
- bus_o  out  DATA_W  value this block drives onto the W-bus
- bus_oe_o  out  1  bus_o valid/driven
- prog_mode_i  in  1  1 = program mode, 0 = run mode
- prog_valid_i  in  1  write request
- prog_ready_o  out  1  write accepted this cycle when high together with prog_valid_i
- prog_addr_i  in  ADDR_W  write address
- prog_data_i  in  DATA_W  write data
- pc_o  out  ADDR_W  current PC
- mar_o  out  ADDR_W  current MAR
- run_o  out  1  FSM is in RUN
- bus_conflict_o  out  1  sticky: Ep and CE were asserted in the same cycle

Behaviour:
- Reset values (async, on rstn_i low): FSM=PROG, PC=0, MAR=0, bus_conflict_o=0, run_o=0, bus_oe_o=0, bus_o=0, prog_ready_o=1. RAM contents are not reset.
- FSM states PROG and RUN:
  - PROG->RUN at the clock edge where prog_mode_i=0; the same edge clears PC and MAR to 0.
  - RUN->PROG at the edge where prog_mode_i=1; the current cycle's control bits still act at that edge.
- In PROG:
  - ctrl_word_i is ignored; bus_oe_o=0; prog_ready_o=1.
  - ram[prog_addr_i] <= prog_data_i on each edge with prog_valid_i=1, one word per cycle, no back-pressure.
- In RUN:
  - prog_ready_o=0; prog_valid_i is ignored and never writes.
  - Cp: PC <= PC+1 at the edge, modulo 2**ADDR_W (15 -> 0 wrap, no flag).
  - Ep: combinationally, bus_o = zero-extended PC and bus_oe_o=1.
  - Lm: MAR <= bus_i[ADDR_W-1:0] at the edge.
  - CE: combinationally, bus_o = ram[MAR] (asynchronous read, zero latency) and bus_oe_o=1.
  - Ep together with CE: Ep has priority (bus_o=PC), and bus_conflict_o sets and stays set until reset.
  - Cp together with Ep: the bus shows the pre-increment PC; the increment takes effect at the edge.
  - Lm together with CE: the bus shows ram[old MAR]; MAR updates at the edge.
  - No Ep and no CE: bus_oe_o=0, bus_o=0.
- Control bits not owned by this block are ignored.
- All outputs other than bus_o and bus_oe_o are registered.

Optional Feature:
- Macro SAP1_MEM_PARITY_EN.
- With the macro defined:
  - Each RAM word stores an extra even-parity bit, computed on a program write.
  - Adds output parity_err_o (1 bit, reset 0).
  - On any CE read in RUN whose stored parity mismatches, parity_err_o sets sticky at that edge; bus_o still shows the data bits.
- Without the macro: no parity storage and no parity_err_o port.

Decomposition:
- sap1_pkg holds:
  - control-word bit indices: CP=11, EP=10, LM=9, CE=8, LI=7, EI=6, LA=5, EA=4, SU=3, EU=2, LB=1, LO=0, all active-high;
  - FSM state typedef {PROG, RUN};
  - DATA_W/ADDR_W defaults.
- One natural sub-module: sap1_ram16x8, with synchronous write, asynchronous read and the optional parity bit.
- PC, MAR, the FSM and the bus mux stay in the top module.

Test Plan:
- Reset, then 16 program writes of ram[i]=8'h10+i with prog_mode_i=1 -> prog_ready_o=1 every cycle; after PROG->RUN, run_o=1, pc_o=0, mar_o=0.
- RUN: Ep+Lm with bus_i looped from bus_o, next cycle CE -> bus_o=8'h10 (ram[0]), bus_oe_o=1 on both cycles, mar_o=0.
- RUN: Cp on 17 consecutive cycles -> pc_o goes 1..15, 0, 1 (wraps with no flag).
- RUN: Ep+Cp in one cycle with PC=5 -> bus_o=8'h05 that cycle, pc_o=6 next cycle.
- RUN: Ep+CE together with PC=3, MAR=7 -> bus_o=8'h03 and bus_conflict_o=1 from the next edge, still 1 after 10 idle cycles; prog_valid_i pulses in RUN leave RAM unchanged.
- Assert rstn_i low mid-run with PC=9 -> pc_o=0, FSM=PROG, bus_oe_o=0 immediately (async); RAM readback after re-entering RUN still returns the pre-reset data.
